// File: rtl/display_scan_controller_pkg.sv
// Shared definitions for the multiplexed 7-segment display: scan states,
// the blank segment pattern and the active-low hex glyph table.
package display_scan_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = 7'b1000000;
            4'h1:    pattern = 7'b1111001;
            4'h2:    pattern = 7'b0100100;
            4'h3:    pattern = 7'b0110000;
            4'h4:    pattern = 7'b0011001;
            4'h5:    pattern = 7'b0010010;
            4'h6:    pattern = 7'b0000010;
            4'h7:    pattern = 7'b1111000;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0010000;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b0000011;
            4'hC:    pattern = 7'b1000110;
            4'hD:    pattern = 7'b0100001;
            4'hE:    pattern = 7'b0000110;
            4'hF:    pattern = 7'b0001110;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/display_scan_controller_decoder.sv
// Combinational hex-to-7-segment decoder (active-low), shared by all
// display users on the board.
module seven_seg_decoder
    import display_scan_controller_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the glyph for one nibble.
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// dead-time blanking, leading-zero suppression and a frame-synchronous write buffer.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      enable,
    input  logic                      wr_valid,
    input  logic [4*NUM_DIGITS-1:0]   wr_data,
    input  logic [NUM_DIGITS-1:0]     wr_dp,
    output logic                      wr_ready,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t               state_r;
    scan_state_t               state_next_s;
    logic [IDX_W-1:0]          idx_r;
    logic [IDX_W-1:0]          idx_next_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [CNT_W-1:0]          cnt_next_s;
    logic                      frame_end_s;
    logic                      commit_s;
    logic                      accept_s;

    logic [4*NUM_DIGITS-1:0]   active_data_r;
    logic [NUM_DIGITS-1:0]     active_dp_r;
    logic [4*NUM_DIGITS-1:0]   pend_data_r;
    logic [NUM_DIGITS-1:0]     pend_dp_r;
    logic                      pend_full_r;

    logic [3:0]                digit_nibble_s;
    logic [6:0]                digit_seg_s;
    logic                      upper_nonzero_s;
    logic                      suppress_s;

    logic [NUM_DIGITS-1:0]     an_s;
    logic [6:0]                seg_s;
    logic                      dp_s;
    logic [NUM_DIGITS-1:0]     an_r;
    logic [6:0]                seg_r;
    logic                      dp_r;
    logic                      frame_done_r;

    assign wr_ready   = ~pend_full_r;
    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign frame_done = frame_done_r;

    // Pending is only ever loaded while empty, so it can never collide with a commit.
    assign accept_s = wr_valid & ~pend_full_r;
    assign commit_s = pend_full_r & ((state_r == ST_IDLE) | frame_end_s);

    // Scan state, digit index and blanking counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic; dropping enable always returns to a dark IDLE at digit 0.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        cnt_next_s   = cnt_r;
        frame_end_s  = 1'b0;
        if (!enable) begin
            state_next_s = ST_IDLE;
            idx_next_s   = {IDX_W{1'b0}};
            cnt_next_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tick) begin
                        state_next_s = ST_BLANK;
                        idx_next_s   = {IDX_W{1'b0}};
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_BLANK: begin
                    if (cnt_r == CNT_LAST) begin
                        state_next_s = ST_DRIVE;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_next_s   = cnt_r + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (tick) begin
                        state_next_s = ST_BLANK;
                        cnt_next_s   = {CNT_W{1'b0}};
                        if (idx_r == IDX_LAST) begin
                            idx_next_s  = {IDX_W{1'b0}};
                            frame_end_s = 1'b1;
                        end else begin
                            idx_next_s  = idx_r + IDX_W'(1);
                        end
                    end else begin
                        state_next_s = ST_DRIVE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    idx_next_s   = {IDX_W{1'b0}};
                    cnt_next_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Double buffer: writes land in pending, reach active only at frame edges or in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_data_r <= {(4*NUM_DIGITS){1'b0}};
            active_dp_r   <= {NUM_DIGITS{1'b0}};
            pend_data_r   <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r     <= {NUM_DIGITS{1'b0}};
            pend_full_r   <= 1'b0;
        end else if (commit_s) begin
            active_data_r <= pend_data_r;
            active_dp_r   <= pend_dp_r;
            pend_full_r   <= 1'b0;
        end else if (accept_s) begin
            pend_data_r   <= wr_data;
            pend_dp_r     <= wr_dp;
            pend_full_r   <= 1'b1;
        end else begin
            pend_full_r   <= pend_full_r;
        end
    end

    assign digit_nibble_s = active_data_r[{idx_r, 2'b00} +: 4];

    seven_seg_decoder u_decoder (
        .nibble (digit_nibble_s),
        .seg    (digit_seg_s)
    );

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        upper_nonzero_s = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            upper_nonzero_s = upper_nonzero_s
                | ((j >= int'(idx_r)) && (active_data_r[j*4 +: 4] != 4'h0));
        end
        suppress_s = (LZ_SUPPRESS != 0) && (idx_r != {IDX_W{1'b0}})
                     && !upper_nonzero_s && !active_dp_r[idx_r];
    end

    // Drive pattern for the current state; enable gates it so dropping enable goes dark at once.
    always_comb begin
        an_s  = {NUM_DIGITS{1'b1}};
        seg_s = SEG_BLANK;
        dp_s  = 1'b1;
        if (enable && (state_r == ST_DRIVE)) begin
            an_s[idx_r] = 1'b0;
            seg_s       = suppress_s ? SEG_BLANK : digit_seg_s;
            dp_s        = ~active_dp_r[idx_r];
        end else begin
            an_s  = {NUM_DIGITS{1'b1}};
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r         <= {NUM_DIGITS{1'b1}};
            seg_r        <= SEG_BLANK;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_s;
            seg_r        <= seg_s;
            dp_r         <= dp_s;
            frame_done_r <= frame_end_s;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: expected digit patterns are
// queued when a tick is issued and compared when the digit lights up.
module tb_display_scan_controller;

    localparam int N  = 4;
    localparam int BC = 16;
    localparam logic [6:0] HEX_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst, tick, enable, wr_valid;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic        wr_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int          checks = 0;
    int          failures = 0;
    int          fd_count = 0;
    int          shown_idx = -1;
    logic [15:0] cur_data = 16'h0000;
    logic [3:0]  cur_dp = 4'h0;
    logic [11:0] sb [$];

    display_scan_controller #(.NUM_DIGITS(N), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .enable(enable),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_dp(wr_dp), .wr_ready(wr_ready),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [11:0] exp_digit(input int i, input logic [15:0] d, input logic [3:0] p);
        logic [3:0] a;
        logic [6:0] s;
        logic       upper_zero;
        a = 4'b1111;
        a[i] = 1'b0;
        upper_zero = 1'b1;
        for (int j = i; j < N; j++) if (d[4*j +: 4] != 4'h0) upper_zero = 1'b0;
        s = HEX_TAB[d[4*i +: 4]];
        if (i > 0 && upper_zero && !p[i]) s = 7'h7F;
        return {a, s, ~p[i]};
    endfunction

    task automatic do_write(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk); wr_valid = 1'b1; wr_data = d; wr_dp = p;
        @(negedge clk); wr_valid = 1'b0;
    endtask

    // Pulse tick, then wait for the next lit digit, counting dark cycles before it.
    task automatic step(output int dark, output logic [11:0] obs, output bit timeout);
        bit seen;
        seen = 1'b0; dark = 0; timeout = 1'b1; obs = 12'hxxx;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        shown_idx = (shown_idx + 1) % N;
        for (int c = 0; c < 64 && timeout; c++) begin
            if (an === 4'hF) begin seen = 1'b1; dark++; end
            else if (seen) begin obs = {an, seg, dp}; timeout = 1'b0; end
            if (timeout) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; tick = 1'b0; wr_valid = 1'b0; wr_data = 16'h0000; wr_dp = 4'h0;
        repeat (3) @(negedge clk);
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an: got %h want %h", an, 4'hF); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %h want %h", seg, 7'h7F); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b want 1", dp); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_scan();
        int dark, fd0, nxt;
        bit to, from_idle;
        logic [11:0] obs, e;
        enable = 1'b1;
        do_write(16'h12AF, 4'h0);
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL scan_ready_low: got %b want 0", wr_ready); end
        @(negedge clk);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL scan_ready_high: got %b want 1", wr_ready); end
        cur_data = 16'h12AF; cur_dp = 4'h0;
        fd0 = fd_count;
        for (int k = 0; k < 5; k++) begin
            from_idle = (shown_idx < 0);
            nxt = (shown_idx + 1) % N;
            sb.push_back(exp_digit(nxt, cur_data, cur_dp));
            step(dark, obs, to);
            e = sb.pop_front();
            checks++; if (to || obs !== e) begin failures++; $display("FAIL scan_digit%0d: got %h want %h", nxt, obs, e); end
            // From IDLE the IDLE cycle itself is dark as well.
            checks++; if (dark != (from_idle ? BC + 1 : BC)) begin failures++; $display("FAIL scan_dark%0d: got %0d want %0d", nxt, dark, from_idle ? BC + 1 : BC); end
            repeat (60) @(negedge clk);
            checks++; if ({an, seg, dp} !== e) begin failures++; $display("FAIL scan_hold%0d: got %h want %h", nxt, {an, seg, dp}, e); end
            if (k == 3) begin
                checks++; if (fd_count != fd0) begin failures++; $display("FAIL scan_no_frame_done: got %0d want %0d", fd_count, fd0); end
            end
        end
        checks++; if (fd_count != fd0 + 1) begin failures++; $display("FAIL scan_frame_done: got %0d want %0d", fd_count, fd0 + 1); end
    endtask

    task automatic test_lz();
        int dark, nxt;
        bit to;
        logic [11:0] obs, e;
        for (int pass = 0; pass < 2; pass++) begin
            enable = 1'b0;
            @(negedge clk);
            shown_idx = -1;
            cur_data = 16'h0005;
            cur_dp = (pass == 0) ? 4'b0000 : 4'b0100;
            do_write(cur_data, cur_dp);
            @(negedge clk);
            enable = 1'b1;
            for (int k = 0; k < N; k++) begin
                nxt = (shown_idx + 1) % N;
                sb.push_back(exp_digit(nxt, cur_data, cur_dp));
                step(dark, obs, to);
                e = sb.pop_front();
                checks++; if (to || obs !== e) begin failures++; $display("FAIL lz_p%0d_digit%0d: got %h want %h", pass, nxt, obs, e); end
            end
        end
    endtask

    task automatic test_midframe_write();
        int dark, nxt, fd0;
        bit to;
        logic [11:0] obs, e;
        for (int k = 0; k < 2; k++) begin
            nxt = (shown_idx + 1) % N;
            sb.push_back(exp_digit(nxt, cur_data, cur_dp));
            step(dark, obs, to);
            e = sb.pop_front();
            checks++; if (to || obs !== e) begin failures++; $display("FAIL mid_pre_digit%0d: got %h want %h", nxt, obs, e); end
        end
        do_write(16'hC3D9, 4'b0001);
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_low: got %b want 0", wr_ready); end
        for (int k = 0; k < 2; k++) begin
            nxt = (shown_idx + 1) % N;
            sb.push_back(exp_digit(nxt, cur_data, cur_dp));
            step(dark, obs, to);
            e = sb.pop_front();
            checks++; if (to || obs !== e) begin failures++; $display("FAIL mid_old_digit%0d: got %h want %h", nxt, obs, e); end
        end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_held: got %b want 0", wr_ready); end
        fd0 = fd_count;
        cur_data = 16'hC3D9; cur_dp = 4'b0001;
        for (int k = 0; k < N; k++) begin
            nxt = (shown_idx + 1) % N;
            sb.push_back(exp_digit(nxt, cur_data, cur_dp));
            step(dark, obs, to);
            e = sb.pop_front();
            checks++; if (to || obs !== e) begin failures++; $display("FAIL mid_new_digit%0d: got %h want %h", nxt, obs, e); end
            if (k == 0) begin
                checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_back: got %b want 1", wr_ready); end
                checks++; if (fd_count != fd0 + 1) begin failures++; $display("FAIL mid_frame_done: got %0d want %0d", fd_count, fd0 + 1); end
            end
        end
    endtask

    task automatic test_blank_tick();
        int dark, nxt;
        bit lit;
        logic [11:0] obs, e;
        nxt = (shown_idx + 1) % N;
        sb.push_back(exp_digit(nxt, cur_data, cur_dp));
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        shown_idx = nxt;
        dark = 0; lit = 1'b0; obs = 12'hxxx;
        for (int c = 0; c < 40; c++) begin
            if (!lit) begin
                if (an === 4'hF) dark++;
                else if (dark > 0) begin lit = 1'b1; obs = {an, seg, dp}; end
            end
            tick = (c == 5);
            @(negedge clk);
        end
        tick = 1'b0;
        e = sb.pop_front();
        checks++; if (!lit || obs !== e) begin failures++; $display("FAIL blank_tick_digit: got %h want %h", obs, e); end
        checks++; if (dark != BC) begin failures++; $display("FAIL blank_tick_dark: got %0d want %0d", dark, BC); end
        repeat (100) @(negedge clk);
        checks++; if ({an, seg, dp} !== e) begin failures++; $display("FAIL blank_tick_hold: got %h want %h", {an, seg, dp}, e); end
    endtask

    task automatic test_enable();
        int dark, nxt;
        bit to;
        logic [11:0] obs, e;
        while (shown_idx != 2) begin
            nxt = (shown_idx + 1) % N;
            sb.push_back(exp_digit(nxt, cur_data, cur_dp));
            step(dark, obs, to);
            e = sb.pop_front();
            checks++; if (to || obs !== e) begin failures++; $display("FAIL en_pre_digit%0d: got %h want %h", nxt, obs, e); end
        end
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL en_off_an: got %h want %h", an, 4'hF); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL en_off_seg: got %h want %h", seg, 7'h7F); end
        repeat (10) @(negedge clk);
        enable = 1'b1;
        shown_idx = -1;
        for (int k = 0; k < 2; k++) begin
            nxt = (shown_idx + 1) % N;
            sb.push_back(exp_digit(nxt, cur_data, cur_dp));
            step(dark, obs, to);
            e = sb.pop_front();
            checks++; if (to || obs !== e) begin failures++; $display("FAIL en_restart_digit%0d: got %h want %h", nxt, obs, e); end
        end
    endtask

    task automatic test_reset_mid();
        int dark, nxt;
        bit to;
        logic [11:0] obs, e;
        do_write(16'h4321, 4'hF);
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rstmid_pending: got %b want 0", wr_ready); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL rstmid_an: got %h want %h", an, 4'hF); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL rstmid_seg: got %h want %h", seg, 7'h7F); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL rstmid_dp: got %b want 1", dp); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rstmid_frame_done: got %b want 0", frame_done); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rstmid_wr_ready: got %b want 1", wr_ready); end
        rst = 1'b0;
        shown_idx = -1; cur_data = 16'h0000; cur_dp = 4'h0;
        for (int k = 0; k < 2; k++) begin
            nxt = (shown_idx + 1) % N;
            sb.push_back(exp_digit(nxt, cur_data, cur_dp));
            step(dark, obs, to);
            e = sb.pop_front();
            checks++; if (to || obs !== e) begin failures++; $display("FAIL rstmid_digit%0d: got %h want %h", nxt, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_midframe_write();
        test_blank_tick();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Time-multiplexed scan controller for the board's common-anode 4-digit 7-segment display. It consumes the 1-cycle refresh tick from the display clock divider and drives one digit per tick. A dead-time blanking interval before each digit suppresses ghosting. A double-buffered write port lets the datapath post new values, which are applied only at frame boundaries so a frame never tears.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (index 0 = least significant, rightmost).
BLANK_CYCLES, 16, clk cycles with all anodes off before each digit is driven; must be less than the tick period.
LZ_SUPPRESS, 1, 1 = blank leading zero digits; 0 = show all digits.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
tick  in  1  refresh strobe from the clock divider; high for exactly one clk cycle.
enable  in  1  scan enable; 0 forces display dark.
wr_valid  in  1  write request.
wr_data  in  4*NUM_DIGITS  hex nibbles; nibble i belongs to digit i.
wr_dp  in  NUM_DIGITS  decimal-point request per digit (1 = lit).
wr_ready  out  1  pending buffer empty; write accepted when wr_valid&&wr_ready.
an  out  NUM_DIGITS  anodes, active-low.
seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
dp  out  1  decimal point, active-low.
frame_done  out  1  1-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset values (next edge after rst=1, including mid-operation):
  - state=IDLE, idx=0, blank counter=0.
  - active and pending buffers=0, pending_full=0.
  - wr_ready=1, an=all 1s, seg=7'h7F, dp=1, frame_done=0.
- Outputs an/seg/dp/frame_done are registered and reflect the state one clk after the state is entered.
- Write port:
  - A handshake captures wr_data/wr_dp into pending and sets pending_full; wr_ready=0 from the next cycle.
  - pending is committed to active when the last digit's slot ends, or on any cycle in IDLE. Commit clears pending_full; wr_ready=1 the following cycle.
  - A write is not accepted on a commit cycle, because wr_ready is 0 then.
- FSM:
  - IDLE: all outputs dark. When enable && tick: go to BLANK, idx=0, counter=0.
  - BLANK: an all 1s, seg 7F, dp 1. Counter increments every clk; when it reaches BLANK_CYCLES-1, go to DRIVE. Ticks arriving in BLANK are ignored.
  - DRIVE: an[idx]=0 and all other anodes 1; seg=decode(active nibble idx); dp=~active_dp[idx]. Hold until tick.
  - On tick in DRIVE, go to BLANK and clear the counter:
    - idx<NUM_DIGITS-1: idx increments.
    - idx==NUM_DIGITS-1: idx wraps to 0, frame_done pulses, pending is committed if full.
- enable=0 in any state: IDLE on the next edge, idx=0, outputs dark. Buffers are preserved.
- Leading-zero suppression (LZ_SUPPRESS=1): digit i>0 shows seg=7F when nibbles i..NUM_DIGITS-1 are all 0 and wr_dp-derived active_dp[i]=0. Digit 0 is always shown.
- Decode (active-low, {g..a}):
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000.
  - 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000.
  - 8 → 0000000, 9 → 0010000, A → 0001000, b → 0000011.
  - C → 1000110, d → 0100001, E → 0000110, F → 0001110.
- idx width is clog2(NUM_DIGITS); the blank counter width covers BLANK_CYCLES. There is no arithmetic overflow: idx wraps explicitly.

Decomposition:
- Shared header display_defs.vh:
  - state encodings IDLE/BLANK/DRIVE;
  - SEG_BLANK=7'h7F;
  - the 16 hex segment patterns.
- Sub-module seven_seg_decoder: combinational, 4-bit nibble in, 7-bit active-low segment out. It is shared with other display users.

Test Plan:
- Reset, enable=1, write 16'h12AF (wr_dp=0), ticks every 100 clks → digits 0..3 show F(0001110), A(0001000), 2(0100100), 1(1111001). Each digit is preceded by 16 dark cycles; frame_done fires once per 4 ticks.
- Write 16'h0005 with LZ_SUPPRESS=1 → digit 0 shows 0010010; digits 1..3 stay 7F while their anode is low. With wr_dp=4'b0100, digit 2 shows seg 1000000 (zero) with dp=0.
- Issue a write mid-frame at idx=1 → wr_ready drops next cycle; the old value is displayed until the frame_done cycle; the new value appears from the next digit-0 slot; wr_ready returns high.
- Pulse tick during BLANK → ignored. DRIVE is entered after exactly 16 cycles and holds until the next tick.
- Deassert enable during DRIVE at idx=2 → an=all 1s next cycle. Re-enable plus a tick restarts at idx=0 with the stored value intact.
- Assert rst during DRIVE with pending_full=1 → all outputs, including wr_ready=1 and an=all 1s, take their reset values on the next edge; active and pending buffers read 0.
